fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline: owns the PC register, drives the IM read address,
//  computes next-PC from redirect requests issued by ID, and holds the IF/ID pipeline register.
//  Branch delay slot is architectural: redirects never squash the instruction already in IF.
//  Flags misaligned or out-of-range fetch addresses so the fetch error (AdEL) travels down the pipe.
// PARAMETERS
//  PC_INIT    32'h0000_3000  reset PC; also the base of IM
//  IM_WORDS   4096           IM depth in words; legal fetch range [PC_INIT, PC_INIT+4*IM_WORDS)
//  EXC_ENTRY  32'h0000_4180  PC loaded on flush
// PORTS
//  clk            in   1   single clock; all state updates on posedge
//  reset          in   1   synchronous, active-high
//  stall          in   1   hazard unit: hold PC and IF/ID
//  flush          in   1   exception/eret: clear IF/ID, PC <= flush_to_epc ? epc : EXC_ENTRY
//  flush_to_epc   in   1   flush target select
//  epc            in   32  eret return address
//  npc_sel        in   2   from ID: SEQ / BRANCH / JUMP / JR (npc_sel_t)
//  br_offset      in   16  branch imm from ID instr (signed, word units)
//  j_index        in   26  jump instr_index from ID instr
//  jr_target      in   32  forwarded rs value for jr/jalr
//  if_pc          out  32  current PC to IM
//  im_instr       in   32  IM read data for if_pc (combinational)
//  id_pc          out  32  IF/ID PC
//  id_instr       out  32  IF/ID instruction
//  id_valid       out  1   IF/ID holds a real fetched instruction
//  id_adel        out  1   fetch address error for id_pc
// BEHAVIOUR
//  Reset: if_pc=PC_INIT; id_pc=PC_INIT; id_instr=0; id_valid=0; id_adel=0. Reset beats all.
//  Priority per edge: reset > flush > stall > normal.
//  Normal: IF/ID <= {if_pc, fetched instr, valid=1, adel}; PC <= next_pc.
//  next_pc (redirect applies only when id_valid=1 and id_adel=0, else SEQ):
//   SEQ    if_pc + 4
//   BRANCH id_pc + 4 + ({{14{br_offset[15]}}, br_offset, 2'b00})   (32-bit wrap, no overflow trap)
//   JUMP   {id_pc_plus4[31:28], j_index, 2'b00}
//   JR     jr_target
//  Since ID is decoding the instr before if_pc, the delay-slot instr (at if_pc) enters IF/ID
//   on the same edge the PC takes the target.
//  adel = (if_pc[1:0]!=0) | (if_pc < PC_INIT) | (if_pc >= PC_INIT+4*IM_WORDS).
//   When adel=1, the instr latched is forced to 32'h0 (nop); im_instr is ignored.
//   A misaligned JR target is fetched and flagged; no stall. The exception is raised downstream.
//  Stall: PC, id_* unchanged; npc_sel/redirect ignored (ID is held and reissues next cycle).
//  Flush: id_instr=0, id_valid=0, id_adel=0, id_pc=new PC; PC <= EXC_ENTRY or epc.
//   Flush overrides stall and any simultaneous redirect.
//  Latency: PC to IF/ID is 1 cycle; redirect is visible on if_pc 1 cycle after the request.
//  The stage holds no other state and needs no FSM beyond the PC/IF-ID registers.
// STRUCTURE
//  cpu_pkg: PC_INIT/EXC_ENTRY defaults, npc_sel_t enum {NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_JR},
//   NOP constant. Shared with the controller in ID.
//  Sub-module npc_calc: combinational next-PC mux and adders, reused by ID for jal link calc.
//  IF/ID register is inline in this module.
// TESTING
//  1. reset 2 cycles, free-run with IM preloaded -> if_pc 0x3000,0x3004,0x3008; id_valid rises one
//     cycle after reset drops.
//  2. beq at 0x3000 with br_offset=3 in ID, npc_sel=BRANCH -> id gets 0x3004 (delay slot), then
//     if_pc=0x3010.
//  3. jr with jr_target=0x3002 -> id_pc=0x3002, id_adel=1, id_instr=0; jr_target=0x2FFC -> adel=1.
//  4. stall held for 3 cycles while npc_sel=JUMP -> if_pc/id_* frozen; jump taken on the first
//     unstalled edge.
//  5. flush with stall=1 and npc_sel=BRANCH -> if_pc=0x4180, id_valid=0; flush_to_epc=1,
//     epc=0x3020 -> if_pc=0x3020.
//  6. reset asserted mid-run with a redirect pending -> next edge if_pc=0x3000 and all id_* at
//     reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/exception vectors, next-PC select encoding, NOP word.
package cpu_pkg;

  localparam logic [31:0] PC_INIT_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;
  localparam logic [31:0] NOP           = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } npc_sel_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, region jump, register jump.
module npc_calc
  import cpu_pkg::*;
(
  input  npc_sel_t    sel,
  input  logic        redirect_en,
  input  logic [31:0] if_pc,
  input  logic [31:0] id_pc,
  input  logic [15:0] br_offset,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  logic        [31:0] id_pc_plus4;
  logic signed [31:0] br_disp;
  logic        [31:0] br_target;
  logic        [31:0] j_target;

  // Branch/jump targets are relative to the delay-slot address (id_pc + 4).
  always_comb begin
    id_pc_plus4 = id_pc + 32'd4;
    br_disp     = {{14{br_offset[15]}}, br_offset, 2'b00};
    br_target   = id_pc_plus4 + $unsigned(br_disp);
    j_target    = {id_pc_plus4[31:28], j_index, 2'b00};
    next_pc     = if_pc + 32'd4;
    if (redirect_en) begin
      case (sel)
        NPC_BRANCH: next_pc = br_target;
        NPC_JUMP:   next_pc = j_target;
        NPC_JR:     next_pc = jr_target;
        default:    next_pc = if_pc + 32'd4;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, IM address, next-PC selection and the IF/ID pipeline register.
// Delay slot is architectural: a redirect never squashes the instruction currently in IF.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_INIT   = PC_INIT_DEF,
  parameter int          IM_WORDS  = 4096,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        flush_to_epc,
  input  logic [31:0] epc,
  input  npc_sel_t    npc_sel,
  input  logic [15:0] br_offset,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] if_pc,
  input  logic [31:0] im_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        id_adel
);

  // One past the last legal fetch address; 33 bits so the bound cannot wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, PC_INIT} + (33'(IM_WORDS) * 33'd4);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic        id_adel_q, id_adel_d;

  logic        fetch_adel;
  logic        redirect_en;
  logic [31:0] next_pc;

  // Fetch address error: misaligned or outside the instruction memory window.
  always_comb begin
    fetch_adel = (pc_q[1:0] != 2'b00) ||
                 (pc_q < PC_INIT) ||
                 ({1'b0, pc_q} >= IM_LIMIT);
  end

  // Only a real, well-formed instruction in ID may steer the PC.
  always_comb begin
    redirect_en = id_valid_q && !id_adel_q;
  end

  npc_calc u_npc_calc (
    .sel         (npc_sel),
    .redirect_en (redirect_en),
    .if_pc       (pc_q),
    .id_pc       (id_pc_q),
    .br_offset   (br_offset),
    .j_index     (j_index),
    .jr_target   (jr_target),
    .next_pc     (next_pc)
  );

  // Next-state for PC and IF/ID: flush beats stall, stall beats normal advance.
  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    id_adel_d  = id_adel_q;
    if (flush) begin
      pc_d       = flush_to_epc ? epc : EXC_ENTRY;
      id_pc_d    = flush_to_epc ? epc : EXC_ENTRY;
      id_instr_d = NOP;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
    end else if (!stall) begin
      pc_d       = next_pc;
      id_pc_d    = pc_q;
      id_instr_d = fetch_adel ? NOP : im_instr;
      id_valid_d = 1'b1;
      id_adel_d  = fetch_adel;
    end
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= PC_INIT;
      id_pc_q    <= PC_INIT;
      id_instr_q <= NOP;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      id_adel_q  <= id_adel_d;
    end
  end

  assign if_pc    = pc_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;
  assign id_valid = id_valid_q;
  assign id_adel  = id_adel_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational IM model.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        flush_to_epc;
  logic [31:0] epc;
  npc_sel_t    npc_sel;
  logic [15:0] br_offset;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [31:0] if_pc;
  logic [31:0] im_instr;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        id_adel;

  int checks   = 0;
  int failures = 0;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .flush_to_epc (flush_to_epc),
    .epc          (epc),
    .npc_sel      (npc_sel),
    .br_offset    (br_offset),
    .j_index      (j_index),
    .jr_target    (jr_target),
    .if_pc        (if_pc),
    .im_instr     (im_instr),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .id_adel      (id_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, address-dependent instruction word per location.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h8C00_0000 ^ a;
  endfunction

  assign im_instr = imem(if_pc);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid, input logic adel);
    check({tag, "_id_pc"}, id_pc, pc);
    check({tag, "_id_instr"}, id_instr, instr);
    check({tag, "_id_valid"}, {31'd0, id_valid}, {31'd0, valid});
    check({tag, "_id_adel"}, {31'd0, id_adel}, {31'd0, adel});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; flush_to_epc = 1'b0;
    epc = 32'h0; npc_sel = NPC_SEQ; br_offset = 16'h0; j_index = 26'h0; jr_target = 32'h0;

    // Reset held two cycles
    step(); step();
    check("rst_if_pc", if_pc, 32'h3000);
    check_id("rst", 32'h3000, 32'h0, 1'b0, 1'b0);

    // Free run: id_valid rises on first edge after reset drops
    reset = 1'b0;
    step();
    check("seq1_if_pc", if_pc, 32'h3004);
    check_id("seq1", 32'h3000, imem(32'h3000), 1'b1, 1'b0);

    // beq at 0x3000 in ID, offset 3: delay slot 0x3004 enters ID, PC -> 0x3010
    npc_sel = NPC_BRANCH; br_offset = 16'd3;
    step();
    check("br_if_pc", if_pc, 32'h3010);
    check_id("br", 32'h3004, imem(32'h3004), 1'b1, 1'b0);
    npc_sel = NPC_SEQ;
    step();
    check("br_seq_if_pc", if_pc, 32'h3014);
    check("br_seq_id_pc", id_pc, 32'h3010);

    // Backward branch from 0x3010: 0x3014 - 8 = 0x300C
    npc_sel = NPC_BRANCH; br_offset = 16'hFFFE;
    step();
    check("bneg_if_pc", if_pc, 32'h300C);
    check("bneg_id_pc", id_pc, 32'h3014);
    npc_sel = NPC_SEQ;

    // jr to misaligned 0x3002: fetched and flagged, instr forced to NOP
    npc_sel = NPC_JR; jr_target = 32'h3002;
    step();
    check("jr_if_pc", if_pc, 32'h3002);
    check("jr_id_pc", id_pc, 32'h300C);
    npc_sel = NPC_SEQ;
    step();
    check("jrmis_if_pc", if_pc, 32'h3006);
    check_id("jrmis", 32'h3002, 32'h0, 1'b1, 1'b1);

    // Redirect ignored while ID holds a faulting fetch
    npc_sel = NPC_JR; jr_target = 32'h3100;
    step();
    check("adel_noredir_if_pc", if_pc, 32'h300A);
    check_id("adel_noredir", 32'h3006, 32'h0, 1'b1, 1'b1);
    npc_sel = NPC_SEQ;

    // eret to 0x2FFC (below IM): flush clears IF/ID, then fetch flagged
    flush = 1'b1; flush_to_epc = 1'b1; epc = 32'h2FFC;
    step();
    check("eret_lo_if_pc", if_pc, 32'h2FFC);
    check_id("eret_lo", 32'h2FFC, 32'h0, 1'b0, 1'b0);
    flush = 1'b0; flush_to_epc = 1'b0;
    step();
    check_id("below", 32'h2FFC, 32'h0, 1'b1, 1'b1);
    step();
    check_id("back_in", 32'h3000, imem(32'h3000), 1'b1, 1'b0);
    check("back_in_if_pc", if_pc, 32'h3004);

    // Upper bound: 0x6FFC legal, 0x7000 out of range
    npc_sel = NPC_JR; jr_target = 32'h6FFC;
    step();
    check("jrhi_if_pc", if_pc, 32'h6FFC);
    npc_sel = NPC_SEQ;
    step();
    check_id("last_word", 32'h6FFC, imem(32'h6FFC), 1'b1, 1'b0);
    step();
    check_id("past_end", 32'h7000, 32'h0, 1'b1, 1'b1);
    check("past_end_if_pc", if_pc, 32'h7004);

    // Flush with stall and branch request: goes to exception entry
    flush = 1'b1; stall = 1'b1; npc_sel = NPC_BRANCH; br_offset = 16'd8;
    step();
    check("flush_if_pc", if_pc, 32'h4180);
    check_id("flush", 32'h4180, 32'h0, 1'b0, 1'b0);
    flush = 1'b0; stall = 1'b0; npc_sel = NPC_SEQ;
    step();
    check("exc_if_pc", if_pc, 32'h4184);
    check_id("exc", 32'h4180, imem(32'h4180), 1'b1, 1'b0);

    // Stall three cycles with a jump pending: everything frozen
    stall = 1'b1; npc_sel = NPC_JUMP; j_index = 26'h000_0C10;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_if_pc", if_pc, 32'h4184);
      check_id("stall", 32'h4180, imem(32'h4180), 1'b1, 1'b0);
    end
    // First unstalled edge takes the jump: {0, 0xC10, 00} = 0x3040
    stall = 1'b0;
    step();
    check("jump_if_pc", if_pc, 32'h3040);
    check_id("jump", 32'h4184, imem(32'h4184), 1'b1, 1'b0);
    npc_sel = NPC_SEQ;
    step();
    check("jump_seq_if_pc", if_pc, 32'h3044);
    check("jump_seq_id_pc", id_pc, 32'h3040);

    // eret to epc 0x3020 with a jr pending
    flush = 1'b1; flush_to_epc = 1'b1; epc = 32'h3020; npc_sel = NPC_JR; jr_target = 32'h3500;
    step();
    check("eret_if_pc", if_pc, 32'h3020);
    check_id("eret", 32'h3020, 32'h0, 1'b0, 1'b0);
    flush = 1'b0; flush_to_epc = 1'b0; npc_sel = NPC_SEQ;
    step();
    check("eret_seq_if_pc", if_pc, 32'h3024);
    check_id("eret_seq", 32'h3020, imem(32'h3020), 1'b1, 1'b0);

    // Reset mid-run with redirect and flush pending: reset wins
    reset = 1'b1; flush = 1'b1; npc_sel = NPC_JUMP; j_index = 26'h3FF_FFFF;
    step();
    check("rst2_if_pc", if_pc, 32'h3000);
    check_id("rst2", 32'h3000, 32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
